// File: rtl/hall_call_panel.sv
// Hall call panel: synchronizes and debounces eight floor-call buttons,
// latches accepted presses into call lamps, and issues one-cycle request
// pulses to the elevator controller. Calls served by the controller (door
// open at that floor) are extinguished, and lit calls are periodically
// retransmitted. An active alarm locks out new calls and retransmission.
module hall_call_panel #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned RETX_CYCLES     = 200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] btn_raw,
    input  logic [2:0] current_floor,
    input  logic       door_open,
    input  logic       alarm,
    output logic [7:0] req,
    output logic [7:0] call_lamp,
    output logic [3:0] pending_count
);

    // Last count value before a differing level is accepted.
    localparam logic [7:0]  DEB_LAST  = 8'(DEBOUNCE_CYCLES - 32'd1);
    // Retransmission is disabled entirely when the period is zero.
    localparam bit          RETX_EN   = (RETX_CYCLES != 32'd0);
    localparam logic [15:0] RETX_LAST = RETX_EN ? 16'(RETX_CYCLES - 32'd1) : 16'd0;

    // Number of set bits in an 8-bit vector.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    logic [7:0]       r_sync1;
    logic [7:0]       r_sync2;
    logic [7:0]       r_deb;
    logic [7:0]       r_deb_d;
    logic [7:0][7:0]  r_cnt;
    logic [15:0]      r_timer;
    logic [7:0]       r_lamp;
    logic [7:0]       r_req;
    logic [3:0]       r_pend;

    logic [7:0]       w_served;
    logic [7:0]       w_press;
    logic [7:0]       w_accept;
    logic [7:0]       w_new;
    logic [7:0]       w_retx;
    logic             w_wrap;
    logic [7:0]       w_lamp_next;
    logic [7:0]       w_req_next;

    // Two-flop synchronizer bringing the raw buttons into the clock domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 8'h00;
            r_sync2 <= 8'h00;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Per-bit debounce: a differing level must persist DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb <= 8'h00;
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= 8'd0;
                end else if (r_cnt[i] == DEB_LAST) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= 8'd0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end
        end
    end

    // Delayed debounced level, used to detect the 0->1 press edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb_d <= 8'h00;
        end else begin
            r_deb_d <= r_deb;
        end
    end

    // Free-running retransmit timer counting 0..RETX_CYCLES-1; parked at 0 when disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= 16'd0;
        end else if (!RETX_EN) begin
            r_timer <= 16'd0;
        end else if (r_timer == RETX_LAST) begin
            r_timer <= 16'd0;
        end else begin
            r_timer <= r_timer + 16'd1;
        end
    end

    // Served decode: the controller has its door open at floor i.
    always_comb begin
        w_served = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (door_open && (current_floor == 3'(i))) begin
                w_served[i] = 1'b1;
            end else begin
                w_served[i] = 1'b0;
            end
        end
    end

    // Lamp and request next-state: served clears first, then alarm-gated presses set.
    always_comb begin
        w_press     = r_deb & ~r_deb_d;
        w_accept    = w_press & ~{8{alarm}} & ~w_served;
        w_lamp_next = (r_lamp | w_accept) & ~w_served;
        w_new       = w_accept & ~r_lamp;
        w_wrap      = RETX_EN && (r_timer == RETX_LAST);
        if (w_wrap && !alarm) begin
            w_retx = r_lamp & ~w_served;
        end else begin
            w_retx = 8'h00;
        end
        w_req_next  = w_new | w_retx;
    end

    // Output registers: lamps, one-cycle request pulses and lamp count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lamp <= 8'h00;
            r_req  <= 8'h00;
            r_pend <= 4'd0;
        end else begin
            r_lamp <= w_lamp_next;
            r_req  <= w_req_next;
            r_pend <= popcount8(w_lamp_next);
        end
    end

    assign req           = r_req;
    assign call_lamp     = r_lamp;
    assign pending_count = r_pend;

endmodule

// File: doc/hall_call_panel.md
Name: hall_call_panel

Overview:
- Sits in front of the elevator controller and acts as its request source.
- Synchronizes and debounces 8 raw floor-call buttons, latches each call into a lamp, and emits one-cycle req pulses on the controller's 8-bit request bus.
- Watches the controller's current_floor/door_open outputs to extinguish served calls, and periodically retransmits calls that are still lit.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive synchronized cycles a new button level must hold before it is accepted (1..255)
RETX_CYCLES, 200, period in cycles of call retransmission; 0 disables retransmission (max 65535)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
btn_raw  input  8  raw asynchronous call buttons; bit i = floor i, 1 = pressed
current_floor  input  3  floor reported by the controller
door_open  input  1  controller door-open indication
alarm  input  1  controller alarm (emergency/overload); locks out new calls
req  output  8  one-cycle call pulses to the controller's req input
call_lamp  output  8  latched call indicators; bit i lit = call to floor i outstanding
pending_count  output  4  number of lit lamps (0..8)

Behaviour:
- Reset: asynchronous on reset_n low; all flops clear. req=0, call_lamp=0, pending_count=0; synchronizers, debounced levels, debounce counters and retransmit timer all 0. Asserting reset mid-operation drops all calls immediately; no pulses are issued on release.
- Sync: each btn_raw bit passes through a 2-flop synchronizer to give sync[i].
- Debounce, per bit:
  - deb[i] holds the accepted level; cnt[i] is 8 bits.
  - If sync[i]==deb[i], cnt[i] is cleared.
  - Otherwise cnt[i] increments. When cnt[i] reaches DEBOUNCE_CYCLES-1 and sync still differs, deb[i] takes sync[i] and cnt[i] clears.
  - Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles is rejected.
- Press event: press[i] = deb[i] rising, i.e. the cycle deb[i] goes 0->1. Releases generate nothing.
- Latency: a clean press held steady produces req[i] and call_lamp[i] high at the clock edge DEBOUNCE_CYCLES+3 edges after the first edge that samples btn_raw high. That is 2 sync edges, DEBOUNCE_CYCLES debounce edges and 1 output register edge.
- Served: served[i] = door_open && current_floor==i, evaluated combinationally from the inputs.
- Lamp update, per cycle, priority high to low:
  1. served[i] -> lamp cleared.
  2. press[i] && !alarm -> lamp set.
  3. Otherwise hold.
- A press at the floor currently being served is discarded: no lamp and no req. A press on an already lit lamp produces no new req pulse and leaves the lamp lit.
- req generation (registered, one cycle wide per event):
  - New: req[i]=1 for the single cycle after an accepted press[i] that set lamp[i] from 0.
  - Retransmit: a 16-bit timer counts 0..RETX_CYCLES-1 continuously and wraps. On the wrap cycle, if alarm=0, req is ORed with (call_lamp & ~served).
  - New and retransmit pulses in the same cycle merge into one pulse per bit.
  - RETX_CYCLES=0: timer held at 0, no retransmission.
- Alarm lockout:
  - While alarm=1, presses are discarded (not queued for later) and retransmission is suppressed. The timer keeps running.
  - Lamps hold, and served clearing remains active.
  - Debounce keeps tracking, so a button held across alarm deassertion does not generate a press.
- pending_count: registered popcount of the next lamp value, so it updates in the same cycle as call_lamp.
- No combinational path from any input to any output.

Test Plan:
- All tests use DEBOUNCE_CYCLES=4, RETX_CYCLES=64.
- Reset: drive btn_raw=8'hFF during reset_n=0, then release with buttons still held -> req=0, call_lamp=0, pending_count=0 during reset. After release, exactly one req pulse per bit at edge 7 and call_lamp=8'hFF, pending_count=8.
- Debounce: btn_raw[3] high for 3 synchronized cycles then low -> no req, lamp 0. Held high 20 cycles -> req=8'h08 for exactly one cycle at edge 7, call_lamp=8'h08, pending_count=1.
- Service clear: lamps 8'h28 lit; drive current_floor=5, door_open=1 -> next edge call_lamp=8'h08, pending_count=1. A press on floor 5 while door open at 5 -> lamp stays 0, no req.
- Retransmit: lamp 8'h81 lit, no service -> req=8'h81 pulses once every 64 cycles. Drive current_floor=7, door_open=1 over a wrap -> req=8'h01 on that wrap.
- Alarm lockout: alarm=1, press floor 2, then alarm=0 while button still held -> no req, lamp 8'h00. Existing lamp 8'h10 holds with no retransmit during alarm, and pulses again at the first wrap after alarm=0.
- Simultaneous: served[4] and a debounced floor-4 press in the same cycle -> lamp[4]=0, no req. Floor-1 and floor-6 presses in the same cycle -> req=8'h42 in one cycle, pending_count=2.
